nn_image_loader: RTL and testbench

- Input-side front end for the neural_network top: takes a byte-wide valid/ready pixel stream, writes one full IMG_W x IMG_H frame into a local image buffer, then drives that buffer onto the NN img array.
- Sequences the network: issues nn_reset, holds nn_enable while the NN runs, and captures digit_out when NN_done rises.
- Returns the classified digit through a valid/ready result port, then re-arms for the next frame.

---
 rtl/nn_image_loader.sv | 133 +++++++++++++
 tb/tb_nn_image_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_image_loader.sv
// Front end for the neural_network top. It buffers one pixel frame, runs the NN
// over that frame, and returns the classified digit on a valid/ready port.
module nn_image_loader #(
    parameter  int IMG_W   = 28,
    parameter  int IMG_H   = 28,
    parameter  int PIX_W   = 8,
    parameter  int TIMEOUT = 65536,
    localparam int N_PIX   = IMG_W * IMG_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic [PIX_W-1:0] img [0:N_PIX-1],
    output logic             nn_reset,
    output logic             nn_enable,
    input  logic             nn_done,
    input  logic [3:0]       nn_digit,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [3:0]       result_digit,
    output logic             frame_err,
    output logic             timeout_err,
    output logic             busy
);

    localparam int PTR_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_RESULT
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // pix_ready is registered and only ever 1 in LOAD, so accept never
    // depends on pix_valid through a combinational path back to the source.
    assign accept   = !reset && (state == S_LOAD) && pix_valid && pix_ready;
    assign nn_reset = reset || (state == S_CLEAR);

    // Image buffer carries no reset: a discarded frame leaves stale pixels.
    always_ff @(posedge clk) begin
        if (accept)
            img[wr_ptr] <= pix_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LOAD;
            wr_ptr       <= '0;
            cnt          <= '0;
            pix_ready    <= 1'b1;
            nn_enable    <= 1'b0;
            result_valid <= 1'b0;
            result_digit <= 4'h0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (wr_ptr != LAST_PTR) begin
                            if (pix_last) begin
                                frame_err <= 1'b1;
                                wr_ptr    <= '0;
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end else begin
                            wr_ptr <= '0;
                            if (pix_last) begin
                                state     <= S_CLEAR;
                                pix_ready <= 1'b0;
                                busy      <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                S_CLEAR: begin
                    cnt       <= '0;
                    nn_enable <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    // A done in the timeout cycle still reports the real digit.
                    if (nn_done) begin
                        result_digit <= nn_digit;
                        result_valid <= 1'b1;
                        nn_enable    <= 1'b0;
                        state        <= S_RESULT;
                    end else if (cnt == LAST_CNT) begin
                        result_digit <= 4'hF;
                        result_valid <= 1'b1;
                        timeout_err  <= 1'b1;
                        nn_enable    <= 1'b0;
                        state        <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        pix_ready    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_LOAD;
                    end
                end
                default: begin
                    state     <= S_LOAD;
                    pix_ready <= 1'b1;
                    nn_enable <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_image_loader.sv
// Directed bench for nn_image_loader: frame capture, framing errors, resets,
// NN completion and timeout, with a small NN latency model.
module tb_nn_image_loader;

    localparam int N = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, rst_t = 1'b1;
    logic       pix_valid = 1'b0, pix_last = 1'b0, result_ready = 1'b0;
    logic [7:0] pix_data = 8'h00;

    logic       pix_ready, nn_reset, nn_enable, nn_done;
    logic [3:0] nn_digit;
    logic       result_valid, frame_err, timeout_err, busy;
    logic [3:0] result_digit;
    logic [7:0] img [0:N-1];

    logic       t_pix_ready, t_nn_reset, t_nn_enable;
    logic       nn_done_t = 1'b0;
    logic [3:0] nn_digit_t = 4'h0;
    logic       t_result_valid, t_frame_err, t_timeout_err, t_busy;
    logic [3:0] t_result_digit;
    logic [7:0] t_img [0:N-1];

    // NN model: done on the 501st enabled cycle, plus a manual override.
    int         run_cnt = 0;
    logic       force_done = 1'b0;
    logic [3:0] model_digit = 4'h7;
    always @(posedge clk) run_cnt <= nn_enable ? run_cnt + 1 : 0;
    assign nn_done  = force_done || (nn_enable && run_cnt == 500);
    assign nn_digit = model_digit;

    nn_image_loader dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .img(img), .nn_reset(nn_reset),
        .nn_enable(nn_enable), .nn_done(nn_done), .nn_digit(nn_digit),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_digit(result_digit), .frame_err(frame_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    nn_image_loader #(.TIMEOUT(64)) dut_t (
        .clk(clk), .reset(rst_t), .pix_valid(pix_valid), .pix_ready(t_pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .img(t_img), .nn_reset(t_nn_reset),
        .nn_enable(t_nn_enable), .nn_done(nn_done_t), .nn_digit(nn_digit_t),
        .result_valid(t_result_valid), .result_ready(result_ready),
        .result_digit(t_result_digit), .frame_err(t_frame_err),
        .timeout_err(t_timeout_err), .busy(t_busy)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nb, input int last_idx, input int off, input bit gaps);
        int not_rdy;
        not_rdy = 0;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = 8'((i + off) % 256);
            pix_last  = (i == last_idx);
            if (!pix_ready) not_rdy++;
            tick();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        check("ready_during_load", not_rdy, 0);
    endtask

    task automatic check_img(input string tag, input int lo, input int hi, input int off);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++)
            if (img[i] !== 8'((i + off) % 256)) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 1);
        check({tag, "_nn_enable"}, nn_enable, 0);
        check({tag, "_res_valid"}, result_valid, 0);
        check({tag, "_res_digit"}, result_digit, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_nn_reset"}, nn_reset, 1);
    endtask

    // Full frame through NN and result handshake; stray beats offered in RESULT.
    task automatic run_frame(input int off, input logic [3:0] digit, input bit gaps);
        int k;
        model_digit = digit;
        send_frame(N, N - 1, off, gaps);
        check("clear_nn_reset", nn_reset, 1);
        check("clear_nn_enable", nn_enable, 0);
        check("clear_pix_ready", pix_ready, 0);
        check("clear_busy", busy, 1);
        tick();
        check("run_nn_reset", nn_reset, 0);
        check("run_nn_enable", nn_enable, 1);
        check_img("img_frame", 0, N - 1, off);
        k = 0;
        while (!result_valid && k < 2000) begin
            tick();
            k++;
        end
        check("done_latency", k, 501);
        check("res_digit", result_digit, digit);
        check("res_nn_enable", nn_enable, 0);
        for (int h = 0; h < 3; h++) begin
            pix_valid = 1'b1;
            pix_data  = 8'hEE;
            pix_last  = 1'b1;
            tick();
            check("res_hold", result_valid, 1);
        end
        pix_valid    = 1'b0;
        pix_last     = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("hs_res_valid", result_valid, 0);
        check("hs_pix_ready", pix_ready, 1);
        check("hs_busy", busy, 0);
        check("no_stray_write", img[0], 8'(off % 256));
    endtask

    initial begin
        int k;
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        #1;
        check("rst_release_nn_reset", nn_reset, 0);

        // Clean frame, digit 7
        run_frame(0, 4'h7, 1'b0);

        // Early pix_last on beat 100
        send_frame(101, 100, 5, 1'b0);
        check("early_frame_err", frame_err, 1);
        check("early_pix_ready", pix_ready, 1);
        check("early_nn_reset", nn_reset, 0);
        check("early_busy", busy, 0);
        tick();
        check("early_err_pulse", frame_err, 0);
        check("early_nn_enable", nn_enable, 0);
        check_img("early_img_new", 0, 100, 5);
        check_img("early_img_old", 101, N - 1, 0);

        // nn_done outside RUN is ignored
        force_done  = 1'b1;
        model_digit = 4'h3;
        tick();
        tick();
        force_done = 1'b0;
        check("ign_done_valid", result_valid, 0);
        check("ign_done_busy", busy, 0);

        run_frame(8'h33, 4'h2, 1'b0);

        // Missing pix_last
        send_frame(N, -1, 9, 1'b0);
        check("miss_frame_err", frame_err, 1);
        check("miss_pix_ready", pix_ready, 1);
        check("miss_busy", busy, 0);
        check("miss_nn_reset", nn_reset, 0);
        tick();
        check("miss_err_pulse", frame_err, 0);

        // Reset at beat 400
        send_frame(400, -1, 8'h40, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_vals("rst400");
        reset = 1'b0;
        run_frame(8'h50, 4'h5, 1'b0);

        // Reset mid-RUN
        send_frame(N, N - 1, 8'h60, 1'b0);
        tick();
        repeat (100) tick();
        check("midrun_enable", nn_enable, 1);
        reset = 1'b1;
        tick();
        check_reset_vals("rstrun");
        reset = 1'b0;
        run_frame(8'h77, 4'h9, 1'b1);

        // Timeout instance; main DUT parked in reset
        reset = 1'b1;
        rst_t = 1'b0;
        tick();
        send_frame(N, N - 1, 8'h11, 1'b0);
        check("to_nn_reset", t_nn_reset, 1);
        tick();
        check("to_nn_enable", t_nn_enable, 1);
        k = 0;
        while (!t_timeout_err && k < 200) begin
            tick();
            k++;
        end
        check("to_cycles", k, 64);
        check("to_res_valid", t_result_valid, 1);
        check("to_res_digit", t_result_digit, 4'hF);
        check("to_nn_enable_off", t_nn_enable, 0);
        tick();
        check("to_err_pulse", t_timeout_err, 0);
        check("to_valid_hold", t_result_valid, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("to_hs_valid", t_result_valid, 0);
        check("to_hs_ready", t_pix_ready, 1);

        // Done in the timeout cycle wins
        send_frame(N, N - 1, 8'h22, 1'b0);
        tick();
        repeat (63) tick();
        nn_done_t  = 1'b1;
        nn_digit_t = 4'h4;
        tick();
        nn_done_t = 1'b0;
        check("prio_digit", t_result_digit, 4'h4);
        check("prio_no_timeout", t_timeout_err, 0);
        check("prio_valid", t_result_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
